otter_iobus_arbiter: RTL and testbench
======================================

// Module: otter_iobus_arbiter
// PURPOSE
//  Shares the single OTTER IOBUS between two masters: M0 = OTTER core, M1 = DMA/debug engine.
//  Round-robin arbitration; one transaction at a time; waits for slave ready, with a timeout.
//  Sits between the Otter_Control IOBUS pins and the MMIO peripheral fabric.
// PARAMETERS
//  TIMEOUT  15  max BUS-state cycles waiting for IOBUS_RDY before forced error; 0 = never time out
//  AW       32  address width
//  DW       32  data width
// PORTS
//  CLK         in   1   single clock, rising edge
//  RST         in   1   asynchronous, active-high reset
//  M0_REQ      in   1   core request; held until M0_ACK
//  M0_WR       in   1   1 = write, 0 = read
//  M0_ADDR     in   AW  core address
//  M0_WDATA    in   DW  core write data
//  M0_ACK      out  1   one-cycle completion pulse to core
//  M1_REQ/M1_WR/M1_ADDR/M1_WDATA/M1_ACK   same as M0_*, for DMA master
//  RDATA       out  DW  read data; valid in ACK cycle; shared by both masters
//  ERR         out  1   valid in ACK cycle: 1 = transaction timed out
//  IOBUS_ADDR  out  AW  slave address
//  IOBUS_OUT   out  DW  slave write data
//  IOBUS_WR    out  1   write strobe, one-cycle pulse
//  IOBUS_RD    out  1   read strobe, held through BUS
//  IOBUS_IN    in   DW  slave read data, sampled when IOBUS_RDY=1
//  IOBUS_RDY   in   1   slave completion
//  BUSY        out  1   1 when state != IDLE
//  OWNER       out  1   master currently or last granted (0 = M0, 1 = M1)
// BEHAVIOUR
//  Reset: state=IDLE, last=1 (M0 wins first tie), all outputs 0, counter 0; RST mid-transaction aborts it, no ACK.
//  FSM states: IDLE -> BUS -> DONE -> IDLE. All outputs registered.
//  IDLE:
//   - No REQ: stay IDLE.
//   - One REQ: grant that master.
//   - Both REQ: grant !last.
//   - On grant: latch WR/ADDR/WDATA, set OWNER, counter=0, go to BUS.
//  BUS:
//   - IOBUS_ADDR/IOBUS_OUT driven from latched values.
//   - Write: IOBUS_WR=1 in first BUS cycle only.
//   - Read: IOBUS_RD=1 for every BUS cycle.
//   - IOBUS_RDY=1: capture IOBUS_IN into RDATA (reads only; writes leave RDATA unchanged), ERR<=0, go to DONE.
//   - Otherwise counter+1. When TIMEOUT!=0 and counter==TIMEOUT-1 without RDY: ERR<=1, RDATA<=0, go to DONE.
//  DONE:
//   - ACK of owner=1 for exactly one cycle; last<=owner; IOBUS_ADDR/OUT/WR/RD=0; go to IDLE.
//  Latency: REQ sampled in IDLE at edge n -> BUS from n+1 -> ACK the cycle after the RDY edge.
//   Minimum 3 cycles per transaction; best-case REQ-to-ACK = 2 cycles.
//  Masters must drop REQ in the ACK cycle.
//   - REQ still high in IDLE after ACK is a new request.
//   - REQ seen in DONE is ignored until IDLE.
//  REQ dropped mid-transaction: transaction completes, ACK still pulsed.
//  Address/data/WR changes after grant are ignored (latched copy used).
//  Counter width is clog2(TIMEOUT+1); it never wraps (bounded by TIMEOUT).
//  Fairness: with both REQs held continuously, grants alternate M0,M1,M0,...
// TESTING
//  1 M0 write: M0_REQ, ADDR=0x1100_0000, WDATA=0xA5, RDY in 1st BUS cycle -> IOBUS_WR 1 cycle, M0_ACK 2 cycles after REQ, ERR=0.
//  2 M1 read: RDY after 3 cycles, IOBUS_IN=0xDEAD_BEEF -> IOBUS_RD held 3 cycles, M1_ACK with RDATA=0xDEADBEEF.
//  3 Contention: both REQ held from reset -> grants M0,M1,M0,M1; OWNER toggles; no master granted twice in a row.
//  4 Timeout: TIMEOUT=15, RDY never set -> ACK after 15 BUS cycles, ERR=1, RDATA=0; next request still served.
//  5 RST asserted mid-BUS -> all outputs 0 immediately, no ACK; after release M0 wins a simultaneous request.
//  6 M0 drops REQ and changes ADDR during BUS -> IOBUS_ADDR keeps latched value; M0_ACK still pulses once.

Source files
------------

// File: rtl/otter_iobus_arbiter.sv
// -----------------------------------------------------------------------------
// otter_iobus_arbiter
//
// Shares the single OTTER IOBUS between two masters: M0 (OTTER core) and
// M1 (DMA/debug engine). Round-robin arbitration, one transaction at a time.
// Each transaction waits for IOBUS_RDY, with an optional timeout that
// completes the transaction with ERR=1.
//
// Transaction flow: IDLE -> BUS -> DONE -> IDLE. Every output is registered.
//
// Ports
//   CLK, RST                      clock (rising edge), async active-high reset
//   Mx_REQ                        request, held by the master until Mx_ACK
//   Mx_WR / Mx_ADDR / Mx_WDATA    transaction descriptor, latched at grant
//   Mx_ACK                        one-cycle completion pulse
//   RDATA, ERR                    read data / timeout flag, valid in ACK cycle
//   IOBUS_ADDR, IOBUS_OUT         slave address / write data during BUS
//   IOBUS_WR                      write strobe, first BUS cycle only
//   IOBUS_RD                      read strobe, held through BUS
//   IOBUS_IN, IOBUS_RDY           slave read data / completion
//   BUSY                          1 while not IDLE
//   OWNER                         master currently or last granted
// -----------------------------------------------------------------------------
module otter_iobus_arbiter #(
   parameter int TIMEOUT = 15,
   parameter int AW      = 32,
   parameter int DW      = 32
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          M0_REQ,
   input  logic          M0_WR,
   input  logic [AW-1:0] M0_ADDR,
   input  logic [DW-1:0] M0_WDATA,
   output logic          M0_ACK,
   input  logic          M1_REQ,
   input  logic          M1_WR,
   input  logic [AW-1:0] M1_ADDR,
   input  logic [DW-1:0] M1_WDATA,
   output logic          M1_ACK,
   output logic [DW-1:0] RDATA,
   output logic          ERR,
   output logic [AW-1:0] IOBUS_ADDR,
   output logic [DW-1:0] IOBUS_OUT,
   output logic          IOBUS_WR,
   output logic          IOBUS_RD,
   input  logic [DW-1:0] IOBUS_IN,
   input  logic          IOBUS_RDY,
   output logic          BUSY,
   output logic          OWNER
);

   // Counter only needs to reach TIMEOUT-1; keep at least one bit when the
   // timeout is disabled so the declaration stays legal.
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state, state_next;
   logic          last, last_next;
   logic [CW-1:0] count, count_next;

   logic          m0_ack_next, m1_ack_next;
   logic [DW-1:0] rdata_next;
   logic          err_next;
   logic [AW-1:0] addr_next;
   logic [DW-1:0] out_next;
   logic          wr_next, rd_next;
   logic          busy_next, owner_next;

   // Grant selection and the winning master's descriptor.
   logic          grant;
   logic          g_wr;
   logic [AW-1:0] g_addr;
   logic [DW-1:0] g_wdata;
   logic          complete;

   // ---------------------------------------------------------------------------
   // Next-state and next-output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path through
      // the case statement can leave one unassigned and infer a latch.
      state_next  = state;
      last_next   = last;
      count_next  = count;
      m0_ack_next = 1'b0;
      m1_ack_next = 1'b0;
      rdata_next  = RDATA;
      err_next    = ERR;
      addr_next   = IOBUS_ADDR;
      out_next    = IOBUS_OUT;
      wr_next     = 1'b0;
      rd_next     = IOBUS_RD;
      owner_next  = OWNER;
      complete    = 1'b0;

      // On a tie the master that did not win last time gets the bus.
      grant   = (M0_REQ && M1_REQ) ? ~last : M1_REQ;
      g_wr    = grant ? M1_WR    : M0_WR;
      g_addr  = grant ? M1_ADDR  : M0_ADDR;
      g_wdata = grant ? M1_WDATA : M0_WDATA;

      unique case (state)
         IDLE: begin
            if (M0_REQ || M1_REQ) begin
               // IOBUS_ADDR/IOBUS_OUT double as the latched copy of the request,
               // so later changes on the master side are ignored.
               owner_next = grant;
               addr_next  = g_addr;
               out_next   = g_wdata;
               wr_next    = g_wr;
               rd_next    = ~g_wr;
               count_next = '0;
               state_next = BUS;
            end
         end

         BUS: begin
            if (IOBUS_RDY) begin
               // IOBUS_RD is held for the whole of a read, so it also tells us
               // whether this transaction is a read.
               if (IOBUS_RD) rdata_next = IOBUS_IN;
               err_next = 1'b0;
               complete = 1'b1;
            end else if (TIMEOUT != 0 && count == CNT_MAX) begin
               err_next   = 1'b1;
               rdata_next = '0;
               complete   = 1'b1;
            end else if (TIMEOUT != 0) begin
               count_next = count + CW'(1);
            end
         end

         DONE: begin
            last_next  = OWNER;
            state_next = IDLE;
         end

         default: state_next = IDLE;
      endcase

      if (complete) begin
         m0_ack_next = ~OWNER;
         m1_ack_next = OWNER;
         addr_next   = '0;
         out_next    = '0;
         wr_next     = 1'b0;
         rd_next     = 1'b0;
         state_next  = DONE;
      end

      busy_next = (state_next != IDLE);
   end

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         last       <= 1'b1;
         count      <= '0;
         M0_ACK     <= 1'b0;
         M1_ACK     <= 1'b0;
         RDATA      <= '0;
         ERR        <= 1'b0;
         IOBUS_ADDR <= '0;
         IOBUS_OUT  <= '0;
         IOBUS_WR   <= 1'b0;
         IOBUS_RD   <= 1'b0;
         BUSY       <= 1'b0;
         OWNER      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the values
         // from before this edge, independent of statement order.
         state      <= state_next;
         last       <= last_next;
         count      <= count_next;
         M0_ACK     <= m0_ack_next;
         M1_ACK     <= m1_ack_next;
         RDATA      <= rdata_next;
         ERR        <= err_next;
         IOBUS_ADDR <= addr_next;
         IOBUS_OUT  <= out_next;
         IOBUS_WR   <= wr_next;
         IOBUS_RD   <= rd_next;
         BUSY       <= busy_next;
         OWNER      <= owner_next;
      end
   end

endmodule

// File: tb/tb_otter_iobus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_otter_iobus_arbiter
//
// Self-checking bench for otter_iobus_arbiter. A transaction-level model
// (round-robin pointer, expected read data, expected bus-cycle count) predicts
// the owner, strobes, ACK timing, RDATA and ERR of every transaction.
// -----------------------------------------------------------------------------
module tb_otter_iobus_arbiter;

   localparam int TIMEOUT = 15;
   localparam int AW      = 32;
   localparam int DW      = 32;

   logic          CLK = 1'b0;
   logic          RST;
   logic          M0_REQ, M0_WR, M1_REQ, M1_WR;
   logic [AW-1:0] M0_ADDR, M1_ADDR;
   logic [DW-1:0] M0_WDATA, M1_WDATA;
   logic          M0_ACK, M1_ACK;
   logic [DW-1:0] RDATA;
   logic          ERR;
   logic [AW-1:0] IOBUS_ADDR;
   logic [DW-1:0] IOBUS_OUT;
   logic          IOBUS_WR, IOBUS_RD;
   logic [DW-1:0] IOBUS_IN;
   logic          IOBUS_RDY;
   logic          BUSY, OWNER;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state.
   logic          model_last;
   logic [DW-1:0] model_rdata;

   always #5 CLK = ~CLK;

   otter_iobus_arbiter #(.TIMEOUT(TIMEOUT), .AW(AW), .DW(DW)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .M0_REQ     (M0_REQ),
      .M0_WR      (M0_WR),
      .M0_ADDR    (M0_ADDR),
      .M0_WDATA   (M0_WDATA),
      .M0_ACK     (M0_ACK),
      .M1_REQ     (M1_REQ),
      .M1_WR      (M1_WR),
      .M1_ADDR    (M1_ADDR),
      .M1_WDATA   (M1_WDATA),
      .M1_ACK     (M1_ACK),
      .RDATA      (RDATA),
      .ERR        (ERR),
      .IOBUS_ADDR (IOBUS_ADDR),
      .IOBUS_OUT  (IOBUS_OUT),
      .IOBUS_WR   (IOBUS_WR),
      .IOBUS_RD   (IOBUS_RD),
      .IOBUS_IN   (IOBUS_IN),
      .IOBUS_RDY  (IOBUS_RDY),
      .BUSY       (BUSY),
      .OWNER      (OWNER)
   );

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic check_all_zero(input string name);
      n_total++;
      if ({M0_ACK, M1_ACK, RDATA, ERR, IOBUS_ADDR, IOBUS_OUT, IOBUS_WR, IOBUS_RD, BUSY, OWNER} !== '0)
         $display("FAIL %s: outputs not all zero ack=%b%b rdata=%h err=%b addr=%h out=%h wr=%b rd=%b busy=%b owner=%b, required all 0",
                  name, M0_ACK, M1_ACK, RDATA, ERR, IOBUS_ADDR, IOBUS_OUT, IOBUS_WR, IOBUS_RD, BUSY, OWNER);
      else n_pass++;
   endtask

   // Runs one transaction starting in IDLE with the current REQ/descriptor
   // inputs. The slave answers after 'delay' BUS cycles (never if delay is at
   // least TIMEOUT). At BUS cycle 'mangle_at' the owner drops REQ and scrambles
   // its descriptor. Ends in the IDLE cycle following ACK.
   task automatic run_txn(input int delay, input logic [DW-1:0] slave_data,
                          input bit drop, input int mangle_at, output logic owner);
      int            n;
      bit            timed_out;
      logic          exp_wr;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_wdata, exp_rdata;
      logic [5:0]    exp_flags;

      if (M0_REQ && M1_REQ) owner = ~model_last;
      else                  owner = M1_REQ;
      exp_wr    = owner ? M1_WR    : M0_WR;
      exp_addr  = owner ? M1_ADDR  : M0_ADDR;
      exp_wdata = owner ? M1_WDATA : M0_WDATA;
      timed_out = (delay >= TIMEOUT);
      n         = timed_out ? TIMEOUT : delay + 1;

      tick;  // grant edge
      for (int j = 0; j < n; j++) begin
         exp_flags = {1'b1, owner, exp_wr && (j == 0), ~exp_wr, 2'b00};
         n_total++;
         if ({BUSY, OWNER, IOBUS_WR, IOBUS_RD, M0_ACK, M1_ACK} !== exp_flags)
            $display("FAIL bus_flags cyc=%0d: got busy/owner/wr/rd/ack0/ack1=%b, required %b",
                     j, {BUSY, OWNER, IOBUS_WR, IOBUS_RD, M0_ACK, M1_ACK}, exp_flags);
         else n_pass++;
         n_total++;
         if (IOBUS_ADDR !== exp_addr || IOBUS_OUT !== exp_wdata)
            $display("FAIL bus_addr_data cyc=%0d: got %h/%h, required %h/%h",
                     j, IOBUS_ADDR, IOBUS_OUT, exp_addr, exp_wdata);
         else n_pass++;

         if (j == mangle_at) begin
            if (owner) begin
               M1_REQ = 1'b0; M1_WR = ~M1_WR; M1_ADDR = ~M1_ADDR; M1_WDATA = ~M1_WDATA;
            end else begin
               M0_REQ = 1'b0; M0_WR = ~M0_WR; M0_ADDR = ~M0_ADDR; M0_WDATA = ~M0_WDATA;
            end
         end

         if (!timed_out && j == delay) begin
            IOBUS_RDY = 1'b1;
            IOBUS_IN  = slave_data;
         end else begin
            IOBUS_IN  = $urandom;  // junk that must not be captured
         end
         tick;
         IOBUS_RDY = 1'b0;
      end

      exp_rdata   = timed_out ? '0 : (exp_wr ? model_rdata : slave_data);
      model_rdata = exp_rdata;

      // ACK cycle
      n_total++;
      if ({M0_ACK, M1_ACK} !== (owner ? 2'b01 : 2'b10))
         $display("FAIL ack_pulse: got ack0/ack1=%b%b, required owner=%b acked", M0_ACK, M1_ACK, owner);
      else n_pass++;
      n_total++;
      if (ERR !== timed_out || RDATA !== exp_rdata)
         $display("FAIL ack_result: got err=%b rdata=%h, required err=%b rdata=%h",
                  ERR, RDATA, timed_out, exp_rdata);
      else n_pass++;
      n_total++;
      if ({IOBUS_WR, IOBUS_RD, IOBUS_ADDR, IOBUS_OUT} !== '0 || BUSY !== 1'b1 || OWNER !== owner)
         $display("FAIL done_outputs: got wr=%b rd=%b addr=%h out=%h busy=%b owner=%b, required bus 0 busy 1 owner %b",
                  IOBUS_WR, IOBUS_RD, IOBUS_ADDR, IOBUS_OUT, BUSY, OWNER, owner);
      else n_pass++;

      if (drop) begin
         if (owner) M1_REQ = 1'b0;
         else       M0_REQ = 1'b0;
      end
      tick;

      // Back in IDLE
      n_total++;
      if ({BUSY, M0_ACK, M1_ACK, IOBUS_WR, IOBUS_RD} !== 5'b0 || OWNER !== owner)
         $display("FAIL idle_after: got busy/ack0/ack1/wr/rd=%b owner=%b, required 00000 owner=%b",
                  {BUSY, M0_ACK, M1_ACK, IOBUS_WR, IOBUS_RD}, OWNER, owner);
      else n_pass++;
      model_last = owner;
   endtask

   task automatic test_reset;
      RST = 1'b1;
      M0_REQ = 0; M0_WR = 0; M0_ADDR = '0; M0_WDATA = '0;
      M1_REQ = 0; M1_WR = 0; M1_ADDR = '0; M1_WDATA = '0;
      IOBUS_IN = '0; IOBUS_RDY = 1'b0;
      model_last  = 1'b1;
      model_rdata = '0;
      tick; tick;
      check_all_zero("reset_state");
      RST = 1'b0;
      tick;
      check_all_zero("idle_after_reset");
   endtask

   task automatic test_m0_write;
      logic own;
      M0_REQ = 1; M0_WR = 1; M0_ADDR = 32'h1100_0000; M0_WDATA = 32'h0000_00A5;
      run_txn(0, 32'h1234_5678, 1, -1, own);
   endtask

   task automatic test_m1_read;
      logic own;
      M1_REQ = 1; M1_WR = 0; M1_ADDR = 32'h1100_0040; M1_WDATA = 32'h5555_0000;
      run_txn(2, 32'hDEAD_BEEF, 1, -1, own);
   endtask

   task automatic test_contention;
      logic own;
      M0_REQ = 1; M0_WR = 0; M0_ADDR = 32'h1100_0100; M0_WDATA = 32'h0;
      M1_REQ = 1; M1_WR = 1; M1_ADDR = 32'h1100_0200; M1_WDATA = 32'hCAFE_F00D;
      for (int k = 0; k < 4; k++) begin
         run_txn(int'($urandom_range(0, 3)), $urandom, 0, -1, own);
         n_total++;
         if (OWNER !== k[0])
            $display("FAIL contention_order txn=%0d: got owner=%b, required %b", k, OWNER, k[0]);
         else n_pass++;
      end
      M0_REQ = 0; M1_REQ = 0;
   endtask

   task automatic test_timeout;
      logic own;
      M0_REQ = 1; M0_WR = 0; M0_ADDR = 32'h1100_0300; M0_WDATA = 32'h0;
      run_txn(100, 32'hFFFF_FFFF, 1, -1, own);
      M1_REQ = 1; M1_WR = 1; M1_ADDR = 32'h1100_0304; M1_WDATA = 32'h0000_0042;
      run_txn(0, 32'h0BAD_0BAD, 1, -1, own);
   endtask

   task automatic test_reset_mid_bus;
      logic own;
      M1_REQ = 1; M1_WR = 0; M1_ADDR = 32'h1100_0400; M1_WDATA = 32'h0;
      tick;  // grant
      tick;  // second BUS cycle
      #2;
      RST = 1'b1;
      #1;
      check_all_zero("reset_mid_bus_async");
      M0_REQ = 1; M0_WR = 1; M0_ADDR = 32'h1100_0500; M0_WDATA = 32'h0000_0077;
      for (int k = 0; k < 2; k++) begin
         tick;
         check_all_zero("reset_held");
      end
      model_last  = 1'b1;
      model_rdata = '0;
      RST = 1'b0;
      run_txn(1, 32'h1111_2222, 1, -1, own);
      n_total++;
      if (own !== 1'b0 || OWNER !== 1'b0)
         $display("FAIL reset_tie_winner: got owner=%b, required 0", OWNER);
      else n_pass++;
      M1_REQ = 0;
   endtask

   task automatic test_req_drop;
      logic own;
      M0_REQ = 1; M0_WR = 0; M0_ADDR = 32'h1100_0600; M0_WDATA = 32'h0;
      run_txn(3, 32'h7E57_DA7A, 1, 1, own);
      tick;
      n_total++;
      if ({M0_ACK, M1_ACK, BUSY} !== 3'b000)
         $display("FAIL req_drop_single_ack: got ack0/ack1/busy=%b%b%b, required 000", M0_ACK, M1_ACK, BUSY);
      else n_pass++;
   endtask

   task automatic test_random;
      logic own;
      logic [1:0] r;
      for (int k = 0; k < 30; k++) begin
         r        = 2'($urandom_range(1, 3));
         M0_REQ   = r[0];
         M1_REQ   = r[1];
         M0_WR    = 1'($urandom);
         M1_WR    = 1'($urandom);
         M0_ADDR  = $urandom;
         M1_ADDR  = $urandom;
         M0_WDATA = $urandom;
         M1_WDATA = $urandom;
         run_txn(int'($urandom_range(0, TIMEOUT + 2)), $urandom, 1,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1, own);
      end
      M0_REQ = 0; M1_REQ = 0;
   endtask

   initial begin
      test_reset;
      test_m0_write;
      test_m1_read;
      test_contention;
      test_timeout;
      test_reset_mid_bus;
      test_req_drop;
      test_random;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
